// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM state encoding,
// default byte width and the stall counter width.
package fifo_arb_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int STALL_CNT_W    = 8;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_A    = 2'd1,
        SEND_B_LO = 2'd2,
        SEND_B_HI = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// Two-requester round-robin grant. On a tie the requester that was not
// served last wins; last_b remembers who won the most recent grant and
// comes out of reset set so that A wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    logic last_b;

    // Grant decision: requests are only honoured while enabled (top is idle)
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            grant_a = req_a & (~req_b | last_b);
            grant_b = req_b & (~req_a | ~last_b);
        end
    end

    // Round-robin history, updated only when a grant is actually issued
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (grant_a) begin
            last_b <= 1'b0;
        end else if (grant_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter merging a single-byte requester (A) and a two-byte
// requester (B) into one FIFO byte stream. B's LO/HI bytes are written
// back to back with no A byte in between; FULL stalls the transfer in place.
// Optional feature: define FIFO_ARB_STATS_EN to add the saturating
// STALL_CNT output counting cycles spent stalled by FULL.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    A_VLD,
    input  logic [DATA_WIDTH-1:0]   A_DATA,
    output logic                    A_ACK,
    input  logic                    B_VLD,
    input  logic [2*DATA_WIDTH-1:0] B_DATA,
    output logic                    B_ACK,
    input  logic                    FULL,
    output logic                    W_INC,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    BUSY
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]  STALL_CNT
`endif
);

    arb_state_t              state;
    arb_state_t              state_next;
    logic [2*DATA_WIDTH-1:0] data_q;
    logic                    grant_a;
    logic                    grant_b;
    logic                    is_idle;
    logic                    write_en;

    assign is_idle = (state == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (CLK),
        .rst     (RST),
        .enable  (is_idle),
        .req_a   (A_VLD),
        .req_b   (B_VLD),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Next state and FIFO-facing outputs; a byte leaves only when FULL is low
    always_comb begin
        state_next = state;
        write_en   = 1'b0;
        WR_DATA    = '0;
        BUSY       = ~is_idle;
        unique case (state)
            IDLE: begin
                if (grant_a) begin
                    state_next = SEND_A;
                end else if (grant_b) begin
                    state_next = SEND_B_LO;
                end
            end
            SEND_A: begin
                write_en = ~FULL;
                WR_DATA  = data_q[DATA_WIDTH-1:0];
                if (~FULL) begin
                    state_next = IDLE;
                end
            end
            SEND_B_LO: begin
                write_en = ~FULL;
                WR_DATA  = data_q[DATA_WIDTH-1:0];
                if (~FULL) begin
                    state_next = SEND_B_HI;
                end
            end
            SEND_B_HI: begin
                write_en = ~FULL;
                WR_DATA  = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
                if (~FULL) begin
                    state_next = IDLE;
                end
            end
        endcase
        W_INC = write_en;
    end

    // State register, captured payload and the one-cycle acknowledge pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            data_q <= '0;
            A_ACK  <= 1'b0;
            B_ACK  <= 1'b0;
        end else begin
            state <= state_next;
            A_ACK <= grant_a;
            B_ACK <= grant_b;
            if (grant_a) begin
                data_q <= {{DATA_WIDTH{1'b0}}, A_DATA};
            end else if (grant_b) begin
                data_q <= B_DATA;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturating count of cycles a transfer sat blocked behind FULL
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
        end else if (~is_idle && FULL && (STALL_CNT != STALL_CNT_MAX)) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end
`endif

endmodule
